// File: rtl/latch_phase_gen_if.sv
// Bundle of run request, width configuration and phase outputs.
// master: drives EN/PH1_W/PH2_W/GAP_W; slave: drives PH1/PH2/PH1_END/PH2_END/BUSY (+CYC_CNT with PHGEN_CYC_CNT_EN).
interface latch_phase_gen_if #(
  parameter int CNT_W = 8
);
  logic             EN;
  logic [CNT_W-1:0] PH1_W;
  logic [CNT_W-1:0] PH2_W;
  logic [CNT_W-1:0] GAP_W;
  logic             PH1;
  logic             PH2;
  logic             PH1_END;
  logic             PH2_END;
  logic             BUSY;
`ifdef PHGEN_CYC_CNT_EN
  logic [15:0]      CYC_CNT;

  modport master (
    output EN, PH1_W, PH2_W, GAP_W,
    input  PH1, PH2, PH1_END, PH2_END, BUSY, CYC_CNT
  );
  modport slave (
    input  EN, PH1_W, PH2_W, GAP_W,
    output PH1, PH2, PH1_END, PH2_END, BUSY, CYC_CNT
  );
`else
  modport master (
    output EN, PH1_W, PH2_W, GAP_W,
    input  PH1, PH2, PH1_END, PH2_END, BUSY
  );
  modport slave (
    input  EN, PH1_W, PH2_W, GAP_W,
    output PH1, PH2, PH1_END, PH2_END, BUSY
  );
`endif
endinterface

// File: rtl/latch_phase_gen.sv
// Two-phase non-overlapping latch enable generator (PH1/gap/PH2/gap).
// Ports: CLK, RST (async high), bus (slave modport). Option: PHGEN_CYC_CNT_EN adds CYC_CNT.
module latch_phase_gen #(
  parameter int CNT_W = 8
) (
  input logic CLK,
  input logic RST,
  latch_phase_gen_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    P1   = 3'd1,
    G1   = 3'd2,
    P2   = 3'd3,
    G2   = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] ph1w_q, ph1w_d;
  logic [CNT_W-1:0] ph2w_q, ph2w_d;
  logic [CNT_W-1:0] gapw_q, gapw_d;
  logic ph1_q, ph1_d;
  logic ph2_q, ph2_d;
  logic e1_q, e1_d;
  logic e2_q, e2_d;
  logic busy_q, busy_d;

  function automatic logic [CNT_W-1:0] clamp(
    input logic [CNT_W-1:0] v
  );
    return (v == '0) ? ONE : v;
  endfunction

  logic [CNT_W-1:0] in_ph1, in_ph2, in_gap;
  assign in_ph1 = clamp(bus.PH1_W);
  assign in_ph2 = clamp(bus.PH2_W);
  assign in_gap = clamp(bus.GAP_W);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ph1w_q  <= '0;
      ph2w_q  <= '0;
      gapw_q  <= '0;
      ph1_q   <= 1'b0;
      ph2_q   <= 1'b0;
      e1_q    <= 1'b0;
      e2_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ph1w_q  <= ph1w_d;
      ph2w_q  <= ph2w_d;
      gapw_q  <= gapw_d;
      ph1_q   <= ph1_d;
      ph2_q   <= ph2_d;
      e1_q    <= e1_d;
      e2_q    <= e2_d;
      busy_q  <= busy_d;
    end
  end

  // Shadows are reloaded only at a period start (IDLE exit or G2 wrap).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ph1w_d  = ph1w_q;
    ph2w_d  = ph2w_q;
    gapw_d  = gapw_q;
    unique case (state_q)
      IDLE: begin
        if (bus.EN) begin
          ph1w_d  = in_ph1;
          ph2w_d  = in_ph2;
          gapw_d  = in_gap;
          cnt_d   = in_ph1 - ONE;
          state_d = P1;
        end
      end
      P1: begin
        if (cnt_q == '0) begin
          cnt_d   = gapw_q - ONE;
          state_d = G1;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      G1: begin
        if (cnt_q == '0) begin
          cnt_d   = ph2w_q - ONE;
          state_d = P2;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      P2: begin
        if (cnt_q == '0) begin
          cnt_d   = gapw_q - ONE;
          state_d = G2;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      G2: begin
        if (cnt_q == '0) begin
          if (bus.EN) begin
            ph1w_d  = in_ph1;
            ph2w_d  = in_ph2;
            gapw_d  = in_gap;
            cnt_d   = in_ph1 - ONE;
            state_d = P1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state and registered with it.
  always_comb begin
    ph1_d  = (state_d == P1);
    ph2_d  = (state_d == P2);
    e1_d   = (state_q == P1) && (state_d == G1);
    e2_d   = (state_q == P2) && (state_d == G2);
    busy_d = (state_d != IDLE);
  end

  assign bus.PH1     = ph1_q;
  assign bus.PH2     = ph2_q;
  assign bus.PH1_END = e1_q;
  assign bus.PH2_END = e2_q;
  assign bus.BUSY    = busy_q;

`ifdef PHGEN_CYC_CNT_EN
  logic [15:0] cyc_q;

  // Counts each PH2_END pulse on the edge that raises it.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cyc_q <= '0;
    end else if (e2_d) begin
      cyc_q <= cyc_q + 16'd1;
    end
  end

  assign bus.CYC_CNT = cyc_q;
`endif

endmodule

// File: tb/tb_latch_phase_gen.sv
// Directed-vector bench for latch_phase_gen.
// Checks reset, period shapes, clamping, EN drop, shadowing and async reset.
module tb_latch_phase_gen;

  logic clk;
  logic rst;
  int   nvec;
  int   nerr;

  latch_phase_gen_if #(.CNT_W(8)) bus ();

  latch_phase_gen #(.CNT_W(8)) dut (
    .CLK(clk),
    .RST(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(
    input logic       en,
    input logic [7:0] a,
    input logic [7:0] b,
    input logic [7:0] g
  );
    bus.EN    = en;
    bus.PH1_W = a;
    bus.PH2_W = b;
    bus.GAP_W = g;
  endtask

  // Patterns are MSB-first over len cycles; after cycle upd_at
  // the new inputs (nen/na/nb/ng) are applied.
  task automatic run_period(
    input string       tag,
    input int          len,
    input logic [15:0] p1,
    input logic [15:0] p2,
    input logic [15:0] e1,
    input logic [15:0] e2,
    input int          upd_at,
    input logic        nen,
    input logic [7:0]  na,
    input logic [7:0]  nb,
    input logic [7:0]  ng
  );
    for (int i = 0; i < len; i++) begin
      int k;
      k = len - 1 - i;
      tick();
      chk($sformatf("%s[%0d]", tag, i),
          {28'd0, bus.PH1, bus.PH2, bus.PH1_END, bus.PH2_END},
          {28'd0, p1[k], p2[k], e1[k], e2[k]});
      chk($sformatf("%s_busy[%0d]", tag, i),
          {31'd0, bus.BUSY}, 32'd1);
      chk("ovl", {31'd0, bus.PH1 & bus.PH2}, 32'd0);
      if (i == upd_at) cfg(nen, na, nb, ng);
    end
  endtask

  initial begin
    nvec = 0;
    nerr = 0;
    rst  = 1'b1;
    cfg(1'b0, 8'd3, 8'd2, 8'd1);
    tick();
    tick();
    chk("rst_outs",
        {27'd0, bus.PH1, bus.PH2, bus.PH1_END, bus.PH2_END, bus.BUSY},
        32'd0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle", {29'd0, bus.PH1, bus.PH2, bus.BUSY}, 32'd0);
    end

    // 3/2/1: period 7
    cfg(1'b1, 8'd3, 8'd2, 8'd1);
    run_period("p321a", 7, 16'b1110000, 16'b0000110,
               16'b0001000, 16'b0000001, 99, 1'b1, 8'd3, 8'd2, 8'd1);
    // PH1_W 3->5 while in P2; current period unchanged
    run_period("p321b", 7, 16'b1110000, 16'b0000110,
               16'b0001000, 16'b0000001, 4, 1'b1, 8'd5, 8'd2, 8'd1);
    run_period("p521", 9, 16'b111110000, 16'b000000110,
               16'b000001000, 16'b000000001, 0, 1'b1, 8'd0, 8'd0, 8'd0);
    // zero widths clamp to 1/1/1: period 4
    run_period("p000a", 4, 16'b1000, 16'b0010,
               16'b0100, 16'b0001, 99, 1'b1, 8'd0, 8'd0, 8'd0);
    run_period("p000b", 4, 16'b1000, 16'b0010,
               16'b0100, 16'b0001, 0, 1'b1, 8'd4, 8'd1, 8'd1);
    // EN dropped in second PH1 cycle: period still completes
    run_period("p411", 7, 16'b1111000, 16'b0000010,
               16'b0000100, 16'b0000001, 1, 1'b0, 8'd4, 8'd1, 8'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_idle",
          {27'd0, bus.PH1, bus.PH2, bus.PH1_END, bus.PH2_END, bus.BUSY},
          32'd0);
    end

    // async reset in P2
    cfg(1'b1, 8'd3, 8'd2, 8'd1);
    for (int i = 0; i < 5; i++) tick();
    chk("pre_rst_ph2", {31'd0, bus.PH2}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_ph2", {31'd0, bus.PH2}, 32'd0);
    chk("rst_busy", {31'd0, bus.BUSY}, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("rel_ph1", {31'd0, bus.PH1}, 32'd1);
    chk("rel_busy", {31'd0, bus.BUSY}, 32'd1);

`ifdef PHGEN_CYC_CNT_EN
    rst = 1'b1;
    cfg(1'b1, 8'd1, 8'd1, 8'd1);
    tick();
    chk("cyc_rst", {16'd0, bus.CYC_CNT}, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    chk("cyc_cnt", {16'd0, bus.CYC_CNT}, 32'd3);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
